// File: rtl/femtosoc_pkg.sv
// Shared window codes, local register offsets, bridge FSM encoding and the
// Wishbone request payload used by the iomem/EFB bridge.
package femtosoc_pkg;

  localparam logic [7:0]  WIN_EFB    = 8'h02;
  localparam logic [7:0]  WIN_GPIO   = 8'h03;

  localparam logic [23:0] OFF_GPIO   = 24'h00_0000;
  localparam logic [23:0] OFF_STATUS = 24'h00_0004;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_REQ = 2'd1,
    RESP   = 2'd2
  } bridge_state_e;

  typedef struct packed {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
  } wb_req_t;

endpackage

// File: rtl/efb_wb_master.sv
// Single-beat Wishbone master towards the EFB: holds the request stable until
// ack or timeout and reports the outcome combinationally to the bridge FSM.
module efb_wb_master
  import femtosoc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  wb_req_t    i_req,
  input  logic [7:0] i_wb_dat,
  input  logic       i_wb_ack,
  output logic       o_wb_cyc,
  output logic       o_wb_stb,
  output logic       o_wb_we,
  output logic [7:0] o_wb_adr,
  output logic [7:0] o_wb_dat,
  output logic       o_done_c,
  output logic       o_timeout_c,
  output logic [7:0] o_rdata_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          r_cyc;
  logic          r_we;
  logic [7:0]    r_adr;
  logic [7:0]    r_dat;
  logic [CW-1:0] r_cnt;

  // Ack is checked before the timeout so a late ack still returns data.
  assign o_done_c    = r_cyc & i_wb_ack;
  assign o_timeout_c = r_cyc & ~i_wb_ack & (r_cnt == CNT_LAST);
  assign o_rdata_c   = i_wb_dat;

  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_cyc;
  assign o_wb_we  = r_we;
  assign o_wb_adr = r_adr;
  assign o_wb_dat = r_dat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= 8'h00;
      r_dat <= 8'h00;
      r_cnt <= '0;
    end else if (i_start) begin
      r_cyc <= 1'b1;
      r_we  <= i_req.we;
      r_adr <= i_req.adr;
      r_dat <= i_req.dat;
      r_cnt <= '0;
    end else if (r_cyc) begin
      if (o_done_c || o_timeout_c) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        r_adr <= 8'h00;
        r_dat <= 8'h00;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/iomem_efb_bridge.sv
// PicoRV32 iomem bridge: decodes the EFB Wishbone window and a small local
// register window (GPIO, STATUS); everything else reads 0 in one cycle.
module iomem_efb_bridge
  import femtosoc_pkg::*;
#(
  parameter logic [7:0]  EFB_BASE   = WIN_EFB,
  parameter logic [7:0]  GPIO_BASE  = WIN_GPIO,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  GPIO_RESET = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  gpio_out,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i
);

  bridge_state_e r_state, w_state_nxt;
  logic          r_ready, w_ready_nxt;
  logic [31:0]   r_rdata, w_rdata_nxt;
  logic [7:0]    r_gpio, w_gpio_nxt;
  logic          r_terr, w_terr_nxt;

  logic          w_win_efb, w_win_loc, w_efb_go, w_busy, w_wb_start;
  logic          w_wb_done_c, w_wb_timeout_c;
  logic [7:0]    w_wb_rdata_c;
  logic [23:0]   w_off;
  wb_req_t       w_req;
  logic          w_unused;

  assign w_win_efb = (iomem_addr[31:24] == EFB_BASE);
  assign w_win_loc = (iomem_addr[31:24] == GPIO_BASE);
  assign w_off     = iomem_addr[23:0];
  // EFB writes that skip byte lane 0 have nothing to carry over the 8-bit bus.
  assign w_efb_go  = w_win_efb && ((iomem_wstrb == 4'b0000) || iomem_wstrb[0]);
  assign w_busy    = (r_state == WB_REQ);
  assign w_req     = {iomem_wstrb[0], iomem_addr[9:2], iomem_wdata[7:0]};
  assign w_unused  = ^iomem_wdata[31:8];

  efb_wb_master #(
    .TIMEOUT (TIMEOUT)
  ) u_wb_master (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_wb_start),
    .i_req       (w_req),
    .i_wb_dat    (wb_dat_i),
    .i_wb_ack    (wb_ack_i),
    .o_wb_cyc    (wb_cyc_o),
    .o_wb_stb    (wb_stb_o),
    .o_wb_we     (wb_we_o),
    .o_wb_adr    (wb_adr_o),
    .o_wb_dat    (wb_dat_o),
    .o_done_c    (w_wb_done_c),
    .o_timeout_c (w_wb_timeout_c),
    .o_rdata_c   (w_wb_rdata_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_gpio  <= GPIO_RESET;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_rdata <= w_rdata_nxt;
      r_gpio  <= w_gpio_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  // Next state plus the registered response/local-register updates.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_rdata_nxt = 32'h0;
    w_gpio_nxt  = r_gpio;
    w_terr_nxt  = r_terr;
    w_wb_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (iomem_valid && !r_ready) begin
          if (w_efb_go) begin
            w_wb_start  = 1'b1;
            w_state_nxt = WB_REQ;
          end else begin
            w_state_nxt = RESP;
            w_ready_nxt = 1'b1;
            if (w_win_loc && (w_off == OFF_GPIO)) begin
              w_rdata_nxt = {24'h0, r_gpio};
              if (iomem_wstrb[0]) w_gpio_nxt = iomem_wdata[7:0];
            end else if (w_win_loc && (w_off == OFF_STATUS)) begin
              w_rdata_nxt = {30'h0, w_busy, r_terr};
              if (iomem_wstrb[0] && iomem_wdata[0]) w_terr_nxt = 1'b0;
            end
          end
        end
      end
      WB_REQ: begin
        if (w_wb_done_c) begin
          w_state_nxt = RESP;
          w_ready_nxt = 1'b1;
          w_rdata_nxt = {24'h0, w_wb_rdata_c};
        end else if (w_wb_timeout_c) begin
          w_state_nxt = RESP;
          w_ready_nxt = 1'b1;
          w_rdata_nxt = 32'hFFFF_FFFF;
          w_terr_nxt  = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign gpio_out    = r_gpio;

endmodule

// File: tb/tb_iomem_efb_bridge.sv
// Directed scoreboard bench for iomem_efb_bridge with a scripted EFB slave.
module tb_iomem_efb_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [7:0]  gpio_out;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o, wb_dat_o;
  logic [7:0]  wb_dat_i = 8'hEE;
  logic        wb_ack_i = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    int          lat;
    int          wbc;
  } exp_t;
  exp_t exp_q[$];

  iomem_efb_bridge dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_out    (gpio_out),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU access; the slave acks in WB cycle ack_at (1-based, <=0 never).
  task automatic access(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input bit chk_rd, input logic [31:0] exp_rd,
                        input int exp_lat, input int ack_at, input logic [7:0] ack_dat,
                        input int exp_wbc, input logic [7:0] exp_adr, input logic exp_we,
                        input logic [7:0] exp_dat);
    exp_t e;
    int   cycles;
    int   wbc;
    bit   got;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    e.chk_rd = chk_rd; e.rd = exp_rd; e.lat = exp_lat; e.wbc = exp_wbc;
    exp_q.push_back(e);
    cycles = 0; wbc = 0; got = 1'b0;
    while (!got && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      wb_ack_i = 1'b0;
      wb_dat_i = 8'hEE;
      if (iomem_ready) begin
        got = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        e = exp_q.pop_front();
        chk({tag, " lat"}, 32'(cycles), 32'(e.lat));
        chk({tag, " wbcycles"}, 32'(wbc), 32'(e.wbc));
        if (e.chk_rd) chk({tag, " rdata"}, iomem_rdata, e.rd);
      end else if (wb_cyc_o) begin
        wbc++;
        if (wbc == 1) begin
          chk({tag, " stb"}, 32'(wb_stb_o), 32'd1);
          chk({tag, " adr"}, 32'(wb_adr_o), 32'(exp_adr));
          chk({tag, " we"},  32'(wb_we_o),  32'(exp_we));
          if (exp_we) chk({tag, " wdat"}, 32'(wb_dat_o), 32'(exp_dat));
        end
        if (wbc == ack_at) begin
          wb_ack_i = 1'b1;
          wb_dat_i = ack_dat;
        end
      end
    end
    chk({tag, " ready seen"}, 32'(got), 32'd1);
    iomem_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ready pulse end"}, 32'(iomem_ready), 32'd0);
    chk({tag, " rdata idle"}, iomem_rdata, 32'h0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst gpio",  32'(gpio_out), 32'hA5);
    chk("rst cyc",   32'(wb_cyc_o), 32'd0);
    chk("rst stb",   32'(wb_stb_o), 32'd0);
    chk("rst we",    32'(wb_we_o),  32'd0);
    chk("rst adr",   32'(wb_adr_o), 32'd0);
    chk("rst dat",   32'(wb_dat_o), 32'd0);
    chk("rst ready", 32'(iomem_ready), 32'd0);
    chk("rst rdata", iomem_rdata, 32'h0);

    access("status0", 32'h0300_0004, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("gpio rd", 32'h0300_0000, 4'h0, 32'h0, 1'b1, 32'hA5, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("gpio wr", 32'h0300_0000, 4'b0001, 32'h0000_003C, 1'b0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    chk("gpio after wr", 32'(gpio_out), 32'h3C);
    access("gpio lane1", 32'h0300_0000, 4'b0010, 32'h0000_7777, 1'b0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    chk("gpio lane1 kept", 32'(gpio_out), 32'h3C);
    access("gpio rd2", 32'h0300_0000, 4'h0, 32'h0, 1'b1, 32'h3C, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);

    access("efb rd", 32'h0200_0028, 4'h0, 32'h0, 1'b1, 32'h0000_005A, 5, 4, 8'h5A, 4, 8'h0A, 1'b0, 8'h00);
    chk("efb rd cyc low", 32'(wb_cyc_o), 32'd0);

    access("efb tmo", 32'h0200_0010, 4'b0001, 32'h0000_0099, 1'b1, 32'hFFFF_FFFF, 256, 0, 8'h00, 255, 8'h04, 1'b1, 8'h99);
    access("status tmo", 32'h0300_0004, 4'h0, 32'h0, 1'b1, 32'h1, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("status w0", 32'h0300_0004, 4'b0001, 32'h0, 1'b0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("status keep", 32'h0300_0004, 4'h0, 32'h0, 1'b1, 32'h1, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("status w1c", 32'h0300_0004, 4'b0001, 32'h1, 1'b0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("status clr", 32'h0300_0004, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);

    access("ack at tmo", 32'h0200_0000, 4'h0, 32'h0, 1'b1, 32'h0000_00C3, 256, 255, 8'hC3, 255, 8'h00, 1'b0, 8'h00);
    access("status race", 32'h0300_0004, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);

    access("unmapped", 32'h0700_0000, 4'h0, 32'h0, 1'b1, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("unmapped wr", 32'h0700_0000, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("efb lane1 wr", 32'h0200_0008, 4'b0010, 32'h0000_1200, 1'b0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    access("loc other", 32'h0300_0008, 4'b0001, 32'h0000_0011, 1'b1, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    chk("loc other gpio", 32'(gpio_out), 32'h3C);

    // Reset asserted while the EFB cycle is outstanding.
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0200_0040;
    iomem_wstrb = 4'h0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid cyc high", 32'(wb_cyc_o), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid rst cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid rst stb", 32'(wb_stb_o), 32'd0);
    chk("mid rst adr", 32'(wb_adr_o), 32'd0);
    chk("mid rst gpio", 32'(gpio_out), 32'hA5);
    iomem_valid = 1'b0;
    pulses = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (iomem_ready || wb_cyc_o) pulses++;
    end
    chk("no resp after rst", 32'(pulses), 32'd0);
    access("post rst wr", 32'h0300_0000, 4'b0001, 32'h0000_005E, 1'b0, 32'h0, 1, 0, 8'h00, 0, 8'h00, 1'b0, 8'h00);
    chk("post rst gpio", 32'(gpio_out), 32'h5E);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
